// File: rtl/serdes_pkg.sv
// serdes_pkg: shared types and constants for the SerDes TX path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serdes_pkg;

   // Serializer control state: IDLE holds the line low, SHIFT streams a word.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // 8b/10b comma K28.5 in both running disparities.
   localparam logic [9:0] K28_5_RDN = 10'b0011111010;
   localparam logic [9:0] K28_5_RDP = 10'b1100000101;

   // Encoded 8b/10b symbol width.
   localparam int DEFAULT_WIDTH = 10;

endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: word handshake in, serial line and status out.
// Latency: n/a (wiring only).
// Backpressure: s_ready from the serializer throttles s_valid/s_data.
// Signals: s_valid/s_ready/s_data word input; ser_out serial line;
//          word_start, fill_active, underrun line status.
interface piso_serializer_if
   import serdes_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             ser_out;
   logic             word_start;
   logic             fill_active;
   logic             underrun;

   // Word source / line consumer side.
   modport master (
      output s_valid, s_data,
      input  s_ready, ser_out, word_start, fill_active, underrun
   );

   // Serializer side.
   modport slave (
      input  s_valid, s_data,
      output s_ready, ser_out, word_start, fill_active, underrun
   );
endinterface

// File: rtl/serdes_hold_buf.sv
// serdes_hold_buf: one-entry word buffer between a valid/ready producer and a pop-driven consumer.
// Latency: a word written on edge N is visible on o_data/o_full right after edge N.
// Backpressure: o_ready = !o_full, low in reset; a pop frees the slot for the following edge only.
// Ports: clk, rst (sync, active-low); i_valid/o_ready/i_data write side;
//        i_pop (only while o_full), o_full/o_data read side.
module serdes_hold_buf
   import serdes_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic [WIDTH-1:0] o_data
);
   logic             r_full;
   logic [WIDTH-1:0] r_data;

   // Push needs an empty slot and pop needs a full one, so they never coincide.
   // Ready depends only on the registered flag, never on the same-edge pop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (i_valid && o_ready) begin
         r_full <= 1'b1;
         r_data <= i_data;
      end else if (i_pop) begin
         r_full <= 1'b0;
      end
   end

   assign o_ready = rst && !r_full;
   assign o_full  = r_full;
   assign o_data  = r_data;
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: WIDTH-bit parallel-in/serial-out transmitter with one-word hold-ahead and optional fill.
// Latency: accept at edge N, first bit on ser_out at edge N+2 from IDLE; gapless at word boundaries when hold is full.
// Backpressure: s_ready = !hold_full (low in reset); hold refills one edge after it is emptied.
// Ports: clk, rst (sync, active-low); bus.slave carries s_valid/s_ready/s_data,
//        ser_out, word_start, fill_active, underrun (all outputs registered except s_ready).
module piso_serializer
   import serdes_pkg::*;
#(
   parameter int               WIDTH     = DEFAULT_WIDTH,
   parameter bit               LSB_FIRST = 1'b1,
   parameter bit               IDLE_FILL = 1'b0,
   parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(K28_5_RDN)
) (
   input logic              clk,
   input logic              rst,
   piso_serializer_if.slave bus
);
   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_sh;
   logic [CW-1:0]    r_bit_cnt;   // bits shifted out after the word's first bit
   logic             r_ser;
   logic             r_word_start;
   logic             r_fill;
   logic             r_underrun;
   logic             r_arm;       // hold seen full in IDLE; restart on the next edge

   logic             w_ready;
   logic             w_hold_full;
   logic [WIDTH-1:0] w_hold_data;
   logic             w_boundary;
   logic             w_idle_go;
   logic             w_emit;
   logic             w_pop;
   logic [WIDTH-1:0] w_emit_word;

   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return LSB_FIRST ? w[0] : w[WIDTH-1];
   endfunction

   function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w);
      return LSB_FIRST ? (w >> 1) : (w << 1);
   endfunction

   serdes_hold_buf #(.WIDTH(WIDTH)) u_hold (
      .clk     (clk),
      .rst     (rst),
      .i_valid (bus.s_valid),
      .o_ready (w_ready),
      .i_data  (bus.s_data),
      .i_pop   (w_pop),
      .o_full  (w_hold_full),
      .o_data  (w_hold_data)
   );

   assign w_boundary  = (r_state == SHIFT) && (r_bit_cnt == LAST_CNT);
   // Restart from IDLE goes through r_arm so the hold write and the
   // shifter load always land on separate edges.
   assign w_idle_go   = !IDLE_FILL && (r_state == IDLE) && r_arm && w_hold_full;
   // IDLE with fill enabled only exists for the first edge after reset.
   assign w_emit      = (r_state == IDLE) ? (IDLE_FILL || w_idle_go)
                                          : (w_boundary && (w_hold_full || IDLE_FILL));
   assign w_pop       = w_emit && w_hold_full;
   // Decision uses the pre-edge hold flag; a word accepted on this edge waits.
   assign w_emit_word = w_hold_full ? w_hold_data : IDLE_WORD;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_sh         <= '0;
         r_bit_cnt    <= '0;
         r_ser        <= 1'b0;
         r_word_start <= 1'b0;
         r_fill       <= 1'b0;
         r_underrun   <= 1'b0;
         r_arm        <= 1'b0;
      end else begin
         r_word_start <= 1'b0;
         r_underrun   <= 1'b0;
         if (w_emit) begin
            r_ser        <= first_bit(w_emit_word);
            r_sh         <= shift_one(w_emit_word);
            r_bit_cnt    <= '0;
            r_word_start <= 1'b1;
            r_fill       <= !w_hold_full;
            r_underrun   <= (r_state == SHIFT) && !w_hold_full;
            r_arm        <= 1'b0;
            r_state      <= SHIFT;
         end else if ((r_state == SHIFT) && !w_boundary) begin
            r_ser     <= first_bit(r_sh);
            r_sh      <= shift_one(r_sh);
            r_bit_cnt <= r_bit_cnt + CW'(1);
         end else if (r_state == SHIFT) begin
            // Boundary with nothing to send and fill disabled: drop to idle.
            r_state    <= IDLE;
            r_ser      <= 1'b0;
            r_fill     <= 1'b0;
            r_underrun <= 1'b1;
            r_bit_cnt  <= '0;
         end else begin
            r_ser <= 1'b0;
            r_arm <= w_hold_full;
         end
      end
   end

   assign bus.s_ready     = w_ready;
   assign bus.ser_out     = r_ser;
   assign bus.word_start  = r_word_start;
   assign bus.fill_active = r_fill;
   assign bus.underrun    = r_underrun;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed vectors and scoreboarded random traffic for piso_serializer.
// Latency: n/a (testbench).
// Backpressure: drivers honour s_ready; every wait on the DUT is cycle-bounded.
module tb_piso_serializer;
   logic clk;
   logic rst;

   int n_chk  = 0;
   int n_pass = 0;

   piso_serializer_if #(.WIDTH(10)) a_if ();
   piso_serializer_if #(.WIDTH(10)) b_if ();
   piso_serializer_if #(.WIDTH(10)) c_if ();
   piso_serializer_if #(.WIDTH(2))  d_if ();
   piso_serializer_if #(.WIDTH(32)) e_if ();

   piso_serializer #(.WIDTH(10), .LSB_FIRST(1'b1), .IDLE_FILL(1'b0)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
   piso_serializer #(.WIDTH(10), .LSB_FIRST(1'b0), .IDLE_FILL(1'b0)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));
   piso_serializer #(.WIDTH(10), .LSB_FIRST(1'b1), .IDLE_FILL(1'b1)) u_c (.clk(clk), .rst(rst), .bus(c_if.slave));
   piso_serializer #(.WIDTH(2),  .LSB_FIRST(1'b1), .IDLE_FILL(1'b0)) u_d (.clk(clk), .rst(rst), .bus(d_if.slave));
   piso_serializer #(.WIDTH(32), .LSB_FIRST(1'b0), .IDLE_FILL(1'b0)) u_e (.clk(clk), .rst(rst), .bus(e_if.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic miss(input string name);
      n_chk++;
      $display("FAIL %s: expected event did not occur by %0t", name, $time);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      a_if.s_valid = 1'b0;
      b_if.s_valid = 1'b0;
      c_if.s_valid = 1'b0;
      d_if.s_valid = 1'b0;
      e_if.s_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_a_ser",   a_if.ser_out,     0);
      chk("rst_a_ws",    a_if.word_start,  0);
      chk("rst_a_under", a_if.underrun,    0);
      chk("rst_a_rdy",   a_if.s_ready,     0);
      chk("rst_b_ser",   b_if.ser_out,     0);
      chk("rst_c_ser",   c_if.ser_out,     0);
      chk("rst_c_fill",  c_if.fill_active, 0);
      chk("rst_c_ws",    c_if.word_start,  0);
      chk("rst_c_rdy",   c_if.s_ready,     0);
      rst = 1'b1;
      #1;
   endtask

   // Directed vectors: word plus its bit sequence in time order (first bit leftmost).
   typedef struct {
      logic [9:0] word;
      logic [9:0] seq_lsb;
      logic [9:0] seq_msb;
   } vec_t;
   vec_t vt [3];

   // Random regression scoreboards.
   bit          rg_on = 1'b0;
   logic [1:0]  d_q [$];
   logic [31:0] e_q [$];
   logic [1:0]  d_acc;
   logic [31:0] e_acc;
   int d_pos = -1, e_pos = -1;
   int d_nw = 0, e_nw = 0, d_under = 0, e_under = 0, d_empty = 0, e_empty = 0;
   bit d_done = 1'b0, e_done = 1'b0;
   int d_to, e_to;

   always @(negedge clk) begin
      if (rg_on) begin
         if (d_if.underrun) d_under++;
         if (d_done && !d_if.word_start) d_empty++;
         d_done = 1'b0;
         if (d_if.word_start) d_pos = 0;
         if (d_pos >= 0) begin
            d_acc[1'(d_pos)] = d_if.ser_out;
            d_pos++;
            if (d_pos == 2) begin
               d_pos  = -1;
               d_done = 1'b1;
               d_nw++;
               if (d_q.size() == 0) miss("w2_word_expected");
               else chk("w2_word", 32'(d_acc), 32'(d_q.pop_front()));
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rg_on) begin
         if (e_if.underrun) e_under++;
         if (e_done && !e_if.word_start) e_empty++;
         e_done = 1'b0;
         if (e_if.word_start) e_pos = 0;
         if (e_pos >= 0) begin
            e_acc[5'(31 - e_pos)] = e_if.ser_out;
            e_pos++;
            if (e_pos == 32) begin
               e_pos  = -1;
               e_done = 1'b1;
               e_nw++;
               if (e_q.size() == 0) miss("w32_word_expected");
               else chk("w32_word", e_acc, e_q.pop_front());
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [29:0] bstream;
      logic [9:0]  bw [3];
      logic [9:0]  fseq;
      logic [9:0]  dseq;
      int          idx;
      int          pos;
      int          nrdy;
      bit          acc;
      logic        exp_ser;

      rst = 1'b0;
      a_if.s_valid = 1'b0; a_if.s_data = '0;
      b_if.s_valid = 1'b0; b_if.s_data = '0;
      c_if.s_valid = 1'b0; c_if.s_data = '0;
      d_if.s_valid = 1'b0; d_if.s_data = '0;
      e_if.s_valid = 1'b0; e_if.s_data = '0;

      vt[0] = '{10'h2A5, 10'b1010010101, 10'b1010100101};
      vt[1] = '{10'h3C1, 10'b1000001111, 10'b1111000001};
      vt[2] = '{10'h001, 10'b1000000000, 10'b0000000001};

      // Single word from IDLE, both bit orders.
      foreach (vt[v]) begin
         do_reset();
         chk("rdy_after_rst", a_if.s_ready, 1);
         a_if.s_valid = 1'b1; a_if.s_data = vt[v].word;
         b_if.s_valid = 1'b1; b_if.s_data = vt[v].word;
         for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            if (j == 0) begin
               a_if.s_valid = 1'b0;
               b_if.s_valid = 1'b0;
               chk("rdy_hold_full", a_if.s_ready, 0);
            end
            if (j >= 2 && j <= 11) begin
               chk("lsb_bit", a_if.ser_out, vt[v].seq_lsb[11-j]);
               chk("msb_bit", b_if.ser_out, vt[v].seq_msb[11-j]);
            end else begin
               chk("lsb_line_low", a_if.ser_out, 0);
               chk("msb_line_low", b_if.ser_out, 0);
            end
            chk("lsb_ws",    a_if.word_start, 32'(j == 2));
            chk("msb_ws",    b_if.word_start, 32'(j == 2));
            chk("lsb_under", a_if.underrun,   32'(j == 12));
            chk("msb_under", b_if.underrun,   32'(j == 12));
         end
      end

      // Back-to-back burst with s_valid held high.
      do_reset();
      bw[0] = 10'h3FF; bw[1] = 10'h000; bw[2] = 10'h155;
      bstream = {10'b1111111111, 10'b0000000000, 10'b1010101010};
      idx = 0; pos = -1; nrdy = 0;
      a_if.s_valid = 1'b1; a_if.s_data = bw[0];
      for (int c = 0; c < 50; c++) begin
         acc = a_if.s_valid && a_if.s_ready;
         if (acc) nrdy++;
         @(negedge clk);
         if (acc) begin
            idx++;
            if (idx < 3) a_if.s_data = bw[idx];
            else a_if.s_valid = 1'b0;
         end
         if (pos < 0 && a_if.word_start) pos = 0;
         if (pos >= 0 && pos < 30) begin
            chk("burst_bit",   a_if.ser_out,    bstream[29-pos]);
            chk("burst_ws",    a_if.word_start, 32'(pos % 10 == 0));
            chk("burst_under", a_if.underrun,   0);
            pos++;
         end else if (pos == 30) begin
            chk("burst_end_under", a_if.underrun, 1);
            chk("burst_end_line",  a_if.ser_out,  0);
            pos++;
         end
      end
      if (pos < 31) miss("burst_stream");
      chk("burst_rdy_windows", nrdy, 3);

      // Fill mode: K28.5 repeats, data injected mid-fill starts at next boundary.
      do_reset();
      fseq = 10'b0101111100;
      dseq = 10'b1010010101;
      for (int p = 0; p <= 40; p++) begin
         @(negedge clk);
         exp_ser = (p >= 30 && p < 40) ? dseq[9-(p-30)] : fseq[9-(p%10)];
         chk("fill_bit",   c_if.ser_out,     exp_ser);
         chk("fill_ws",    c_if.word_start,  32'(p % 10 == 0));
         chk("fill_flag",  c_if.fill_active, 32'(!(p >= 30 && p < 40)));
         chk("fill_under", c_if.underrun,    32'(p == 10 || p == 20 || p == 40));
         if (p == 23) begin
            c_if.s_valid = 1'b1;
            c_if.s_data  = 10'h2A5;
         end
         if (p == 24) begin
            c_if.s_valid = 1'b0;
            chk("fill_hold_full", c_if.s_ready, 0);
         end
      end

      // Reset mid-word with hold full: nothing stale may follow.
      do_reset();
      a_if.s_valid = 1'b1; a_if.s_data = 10'h2A5;
      for (int j = 0; j <= 6; j++) begin
         @(negedge clk);
         if (j == 0) a_if.s_valid = 1'b0;
         if (j == 2) begin
            a_if.s_valid = 1'b1;
            a_if.s_data  = 10'h3FF;
         end
         if (j == 3) begin
            a_if.s_valid = 1'b0;
            chk("mid_hold_full", a_if.s_ready, 0);
         end
      end
      chk("mid_bit4", a_if.ser_out, 0);
      rst = 1'b0;
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         chk("mid_rst_ser",   a_if.ser_out,     0);
         chk("mid_rst_ws",    a_if.word_start,  0);
         chk("mid_rst_fill",  a_if.fill_active, 0);
         chk("mid_rst_under", a_if.underrun,    0);
         chk("mid_rst_rdy",   a_if.s_ready,     0);
      end
      rst = 1'b1;
      #1;
      chk("mid_hold_cleared", a_if.s_ready, 1);
      for (int r = 0; r < 15; r++) begin
         @(negedge clk);
         chk("mid_no_stale_ser", a_if.ser_out,    0);
         chk("mid_no_stale_ws",  a_if.word_start, 0);
         chk("mid_no_stale_und", a_if.underrun,   0);
      end

      // WIDTH=2 and WIDTH=32 with random valid gaps.
      do_reset();
      rg_on = 1'b1;
      fork
         begin
            for (int k = 0; k < 30; k++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               d_if.s_valid = 1'b1;
               d_if.s_data  = 2'($urandom);
               d_to = 0;
               while (!d_if.s_ready && d_to < 100) begin
                  @(negedge clk);
                  d_to++;
               end
               if (d_to >= 100) miss("w2_ready_timeout");
               else d_q.push_back(d_if.s_data);
               @(negedge clk);
               d_if.s_valid = 1'b0;
            end
         end
         begin
            for (int k = 0; k < 30; k++) begin
               repeat ($urandom_range(0, 45)) @(negedge clk);
               e_if.s_valid = 1'b1;
               e_if.s_data  = $urandom;
               e_to = 0;
               while (!e_if.s_ready && e_to < 200) begin
                  @(negedge clk);
                  e_to++;
               end
               if (e_to >= 200) miss("w32_ready_timeout");
               else e_q.push_back(e_if.s_data);
               @(negedge clk);
               e_if.s_valid = 1'b0;
            end
         end
      join
      repeat (100) @(negedge clk);
      rg_on = 1'b0;
      chk("w2_word_count",    d_nw,         30);
      chk("w2_leftover",      d_q.size(),   0);
      chk("w2_underruns",     d_under,      d_empty);
      chk("w32_word_count",   e_nw,         30);
      chk("w32_leftover",     e_q.size(),   0);
      chk("w32_underruns",    e_under,      e_empty);
      chk("w32_underrun_seen", 32'(e_under > 0), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
